// File: rtl/wb_cmd_fifo_pkg.sv
// Shared constants for the Wishbone command FIFO: register map, status/control
// bit positions and the issue FSM encoding.
package tjrpu_pkg;

    localparam logic [1:0] REG_DATA = 2'd0;
    localparam logic [1:0] REG_CTRL = 2'd1;
    localparam logic [1:0] REG_READ = 2'd2;

    localparam int unsigned WB_DW   = 32;
    localparam int unsigned SEL_W   = 4;

    localparam int unsigned ST_EMPTY = 8;
    localparam int unsigned ST_FULL  = 9;
    localparam int unsigned ST_OVF   = 10;
    localparam int unsigned ST_BUSY  = 11;

    localparam int unsigned CTRL_CLR_OVF = 0;
    localparam int unsigned CTRL_FLUSH   = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } issue_state_e;

endpackage

// File: rtl/wb_cmd_fifo_sync_fifo.sv
// Reusable synchronous FIFO with registered pointers and occupancy.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;
    logic [LW-1:0]    level_nxt;

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_comb begin
        level_nxt = level;
        if (flush) begin
            level_nxt = '0;
        end else begin
            level_nxt = level + LW'(do_push) - LW'(do_pop);
        end
    end

    // Storage carries no reset; only pointers and occupancy define validity.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + AW'(1);
                if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            end
            level <= level_nxt;
            full  <= (level_nxt == LW'(DEPTH));
            empty <= (level_nxt == '0);
        end
    end

endmodule

// File: rtl/wb_cmd_fifo.sv
// Wishbone slave that queues management commands and replays them to the core
// over its valid/ready handshake, keeping the last returned rdata for readback.
module wb_cmd_fifo
    import tjrpu_pkg::*;
#(
    parameter int unsigned BITS  = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wbs_stb_i,
    input  logic                wbs_cyc_i,
    input  logic                wbs_we_i,
    input  logic [SEL_W-1:0]    wbs_sel_i,
    input  logic [WB_DW-1:0]    wbs_dat_i,
    input  logic [WB_DW-1:0]    wbs_adr_i,
    output logic                wbs_ack_o,
    output logic [WB_DW-1:0]    wbs_dat_o,
    output logic                core_valid,
    output logic [SEL_W-1:0]    core_wstrb,
    output logic [BITS-1:0]     core_wdata,
    input  logic                core_ready,
    input  logic [BITS-1:0]     core_rdata,
    output logic                irq
);

    localparam int unsigned LW = $clog2(DEPTH) + 1;
    localparam int unsigned CW = SEL_W + BITS;

    issue_state_e     state;
    issue_state_e     state_nxt;
    logic             req;
    logic             wr_req;
    logic             rd_req;
    logic [1:0]       reg_sel;
    logic             push;
    logic             pop;
    logic             complete;
    logic             ctrl_wr;
    logic             flush;
    logic [CW-1:0]    push_data;
    logic [CW-1:0]    head;
    logic [LW-1:0]    level;
    logic             full;
    logic             empty;
    logic             overflow;
    logic [BITS-1:0]  last_rdata;
    logic [WB_DW-1:0] status;
    logic [WB_DW-1:0] rd_mux;
    logic             unused_bits;

    assign req     = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
    assign wr_req  = req & wbs_we_i;
    assign rd_req  = req & ~wbs_we_i;
    assign reg_sel = wbs_adr_i[3:2];
    assign push    = wr_req & ((reg_sel == REG_DATA) | (reg_sel == REG_READ));
    assign ctrl_wr = wr_req & (reg_sel == REG_CTRL);
    assign flush   = ctrl_wr & wbs_dat_i[CTRL_FLUSH];
    assign irq     = overflow;

    assign unused_bits = &{1'b0, wbs_adr_i, wbs_dat_i};

    // Read-only commands carry no strobes and no data.
    assign push_data = (reg_sel == REG_READ) ? '0 : {wbs_sel_i, wbs_dat_i[BITS-1:0]};

    sync_fifo #(
        .WIDTH (CW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (push_data),
        .dout  (head),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        status                 = '0;
        status[LW-1:0]         = level;
        status[ST_EMPTY]       = empty;
        status[ST_FULL]        = full;
        status[ST_OVF]         = overflow;
        status[ST_BUSY]        = (state != IDLE);
        rd_mux                 = '0;
        case (reg_sel)
            REG_DATA: rd_mux = status;
            REG_CTRL: rd_mux = WB_DW'(last_rdata);
            default:  rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // GAP guarantees a low cycle on core_valid between consecutive commands.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        complete  = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (core_ready) begin
                    complete  = 1'b1;
                    state_nxt = GAP;
                end
            end
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            core_valid <= 1'b0;
            core_wstrb <= '0;
            core_wdata <= '0;
            last_rdata <= '0;
        end else if (pop) begin
            core_valid <= 1'b1;
            core_wstrb <= head[CW-1:BITS];
            core_wdata <= head[BITS-1:0];
        end else if (complete) begin
            core_valid <= 1'b0;
            last_rdata <= core_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            overflow  <= 1'b0;
        end else begin
            wbs_ack_o <= req;
            wbs_dat_o <= rd_req ? rd_mux : '0;
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end else if (ctrl_wr && wbs_dat_i[CTRL_CLR_OVF]) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wb_cmd_fifo.sv
// Self-checking bench for wb_cmd_fifo: directed scenarios followed by random
// Wishbone/core traffic, all compared cycle by cycle against a queue-based model.
module tb_wb_cmd_fifo;

    localparam int unsigned BITS  = 16;
    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i, wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        core_valid;
    logic [3:0]  core_wstrb;
    logic [BITS-1:0] core_wdata;
    logic        core_ready;
    logic [BITS-1:0] core_rdata;
    logic        irq;

    always #5 clk = ~clk;

    wb_cmd_fifo #(.BITS(BITS), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .wbs_stb_i  (wbs_stb_i),
        .wbs_cyc_i  (wbs_cyc_i),
        .wbs_we_i   (wbs_we_i),
        .wbs_sel_i  (wbs_sel_i),
        .wbs_dat_i  (wbs_dat_i),
        .wbs_adr_i  (wbs_adr_i),
        .wbs_ack_o  (wbs_ack_o),
        .wbs_dat_o  (wbs_dat_o),
        .core_valid (core_valid),
        .core_wstrb (core_wstrb),
        .core_wdata (core_wdata),
        .core_ready (core_ready),
        .core_rdata (core_rdata),
        .irq        (irq)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: pending commands as a queue plus the command on the core.
    logic [19:0]     m_q[$];
    bit              m_ack;
    logic [31:0]     m_dat;
    bit              m_valid;
    logic [3:0]      m_wstrb;
    logic [15:0]     m_wdata;
    logic [15:0]     m_last;
    bit              m_ovf;
    int              m_phase;   // 0 ready to issue, 1 waiting on core, 2 cooldown
    int              issued;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        bit          rq;
        logic [1:0]  a;
        logic [31:0] st;
        if (reset) begin
            m_q.delete();
            m_ack = 0; m_dat = '0; m_valid = 0; m_wstrb = '0; m_wdata = '0;
            m_last = '0; m_ovf = 0; m_phase = 0;
            return;
        end
        rq = wbs_cyc_i && wbs_stb_i && !m_ack;
        a  = wbs_adr_i[3:2];
        st = 32'(m_q.size());
        if (m_q.size() == 0)     st = st + 32'h100;
        if (m_q.size() == DEPTH) st = st + 32'h200;
        if (m_ovf)               st = st + 32'h400;
        if (m_phase != 0)        st = st + 32'h800;
        m_ack = rq;
        m_dat = '0;
        if (rq && !wbs_we_i) begin
            if (a == 2'd0)      m_dat = st;
            else if (a == 2'd1) m_dat = {16'h0, m_last};
        end
        case (m_phase)
            0: if (m_q.size() > 0) begin
                   {m_wstrb, m_wdata} = m_q.pop_front();
                   m_valid = 1; m_phase = 1; issued++;
               end
            1: if (core_ready) begin
                   m_last = core_rdata; m_valid = 0; m_phase = 2;
               end
            default: m_phase = 0;
        endcase
        if (rq && wbs_we_i) begin
            if (a == 2'd0 || a == 2'd2) begin
                if (m_q.size() < DEPTH)
                    m_q.push_back(a == 2'd0 ? {wbs_sel_i, wbs_dat_i[15:0]} : 20'h0);
                else
                    m_ovf = 1;
            end else if (a == 2'd1) begin
                if (wbs_dat_i[0]) m_ovf = 0;
                if (wbs_dat_i[1]) m_q.delete();
            end
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_eq("ack",   32'(wbs_ack_o),  32'(m_ack));
        check_eq("rdat",  wbs_dat_o,       m_dat);
        check_eq("valid", 32'(core_valid), 32'(m_valid));
        check_eq("wstrb", 32'(core_wstrb), 32'(m_wstrb));
        check_eq("wdata", 32'(core_wdata), 32'(m_wdata));
        check_eq("irq",   32'(irq),        32'(m_ovf));
    endtask

    task automatic wb(input bit we, input logic [1:0] a, input logic [3:0] sel,
                      input logic [31:0] dat, output logic [31:0] rdat);
        wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = we;
        wbs_adr_i = {28'h0, a, 2'b00}; wbs_sel_i = sel; wbs_dat_i = dat;
        cycle();
        rdat = wbs_dat_o;
        wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
        cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    logic [31:0] rd;

    initial begin
        issued = 0;
        reset = 1; wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0;
        wbs_sel_i = '0; wbs_dat_i = '0; wbs_adr_i = '0;
        core_ready = 0; core_rdata = '0;
        idle(2);
        check_eq("rst_valid", 32'(core_valid), 32'h0);
        check_eq("rst_irq",   32'(irq),        32'h0);
        reset = 0;
        idle(1);

        // Single command: valid two cycles after the request
        wb(1, 2'd0, 4'b0011, 32'h0000ABCD, rd);
        check_eq("single_valid", 32'(core_valid), 32'h1);
        check_eq("single_wstrb", 32'(core_wstrb), 32'h3);
        check_eq("single_wdata", 32'(core_wdata), 32'hABCD);
        core_ready = 1; idle(1); core_ready = 0;
        idle(2);
        wb(0, 2'd0, 4'hF, 32'h0, rd);
        check_eq("single_status", rd, 32'h100);

        // Fill past depth with the core stalled
        for (int i = 1; i <= 6; i++) wb(1, 2'd0, 4'hF, 32'(i), rd);
        wb(0, 2'd0, 4'hF, 32'h0, rd);
        check_eq("fill_status", rd, 32'hE04);
        check_eq("fill_irq", 32'(irq), 32'h1);
        wb(1, 2'd1, 4'hF, 32'h1, rd);
        check_eq("clr_irq", 32'(irq), 32'h0);
        core_ready = 1; idle(20); core_ready = 0;

        // Read-only command and rdata readback
        wb(1, 2'd2, 4'hF, 32'hFFFF_FFFF, rd);
        check_eq("ro_wstrb", 32'(core_wstrb), 32'h0);
        core_rdata = 16'h1234; core_ready = 1; idle(1); core_ready = 0; core_rdata = '0;
        idle(2);
        wb(0, 2'd1, 4'hF, 32'h0, rd);
        check_eq("readback", rd, 32'h0000_1234);

        // Ready held high: gaps between back-to-back commands
        core_ready = 1;
        wb(1, 2'd0, 4'h1, 32'h11, rd);
        wb(1, 2'd0, 4'h2, 32'h22, rd);
        idle(8);
        core_ready = 0;

        // Flush while a command is in flight
        for (int i = 0; i < 3; i++) wb(1, 2'd0, 4'hF, 32'(16'h50 + i), rd);
        wb(1, 2'd1, 4'hF, 32'h2, rd);
        wb(0, 2'd0, 4'hF, 32'h0, rd);
        check_eq("flush_status", rd, 32'h900);
        core_ready = 1; idle(1); core_ready = 0;
        idle(6);
        check_eq("flush_no_valid", 32'(core_valid), 32'h0);

        // Reset while a command is in ISSUE
        wb(1, 2'd0, 4'hF, 32'h77, rd);
        idle(1);
        reset = 1; idle(1); reset = 0;
        check_eq("rst_mid_valid", 32'(core_valid), 32'h0);
        wb(0, 2'd0, 4'hF, 32'h0, rd);
        check_eq("rst_mid_status", rd, 32'h100);
        wb(0, 2'd1, 4'hF, 32'h0, rd);
        check_eq("rst_mid_last", rd, 32'h0);

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            wbs_cyc_i  = ($urandom_range(0, 2) != 0);
            wbs_stb_i  = ($urandom_range(0, 3) != 0);
            wbs_we_i   = ($urandom_range(0, 2) != 0);
            wbs_adr_i  = $urandom;
            if ($urandom_range(0, 3) != 0) wbs_adr_i[3:2] = 2'd0;
            wbs_sel_i  = 4'($urandom);
            wbs_dat_i  = $urandom;
            if (wbs_adr_i[3:2] == 2'd1 && wbs_we_i)
                wbs_dat_i[1] = ($urandom_range(0, 7) == 0);
            core_ready = ($urandom_range(0, 3) == 0);
            core_rdata = 16'($urandom);
            reset      = ($urandom_range(0, 599) == 0);
            cycle();
        end
        reset = 0; wbs_cyc_i = 0; wbs_stb_i = 0;
        idle(2);
        check_eq("issued_some", 32'(issued > 100), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_cmd_fifo.md
Name: wb_cmd_fifo

Overview:
- Upstream stage for the counter-style core: a Wishbone slave that buffers management-SoC commands in a FIFO.
- It replays each command to the core over the core's valid/wstrb/wdata -> ready/rdata handshake.
- It decouples bursty Wishbone writes from core timing and captures the core's rdata for later readback.
- Exposes status and an overflow interrupt.

Parameters:
- BITS, 16, core data width (8..32, multiple of 8).
- DEPTH, 4, FIFO entries (power of 2, >= 2).
- LW, $clog2(DEPTH)+1, level counter width (derived, not overridable).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- wbs_stb_i  in  1  WB strobe
- wbs_cyc_i  in  1  WB cycle
- wbs_we_i  in  1  WB write enable
- wbs_sel_i  in  4  WB byte selects
- wbs_dat_i  in  32  WB write data
- wbs_adr_i  in  32  WB address; only [3:2] decoded
- wbs_ack_o  out  1  WB acknowledge
- wbs_dat_o  out  32  WB read data
- core_valid  out  1  command valid to core
- core_wstrb  out  4  byte write strobes to core; 0 means read-only
- core_wdata  out  BITS  write data to core
- core_ready  in  1  core completion pulse, rdata valid with it
- core_rdata  in  BITS  core read data
- irq  out  1  level, equals overflow sticky bit

Behaviour:
- Interface decision: reset is named reset, synchronous, active-high; clock is clk.
- Reset values:
  - wbs_ack_o=0, wbs_dat_o=0
  - core_valid=0, core_wstrb=0, core_wdata=0
  - irq=0, FIFO empty, overflow=0, last_rdata=0, FSM=IDLE
- WB request: req = cyc & stb & ~wbs_ack_o.
  - Ack is registered and asserted the cycle after req, for exactly one cycle.
  - Every address is acked; there are no wait states and no errors.
- Register map, adr[3:2]:
  - 0, write: push {sel, dat[BITS-1:0]}.
  - 0, read: status. [LW-1:0]=level, [8]=empty, [9]=full, [10]=overflow, [11]=busy (FSM != IDLE). All other bits 0.
  - 1, write: control. bit0=1 clears overflow; bit1=1 flushes the FIFO.
  - 1, read: last_rdata, zero-extended.
  - 2, write: push a read-only command (wstrb forced 0, data 0).
  - 2, read: 0.
  - 3: writes ignored; reads 0.
  - wbs_dat_o is loaded on the req cycle and is valid with ack. It is 0 for write requests.
- Push timing: the push happens on the req cycle.
  - If the FIFO is full, the entry is dropped, overflow is set, and the request is still acked.
- Issue FSM:
  - IDLE: if FIFO non-empty, pop the head into issue registers (core_wstrb, core_wdata), assert core_valid, go to ISSUE.
  - ISSUE: hold core_valid and the data stable. On core_ready: capture core_rdata into last_rdata, drop core_valid, go to GAP.
  - GAP: one cycle with core_valid=0, required because the core re-triggers on a held valid. Then go to IDLE.
- Latency: WB write req at cycle N -> ack at N+1 -> core_valid at N+2 if the FSM was idle and the FIFO was empty. Back-to-back commands issue at a minimum of 3 cycles apart (IDLE, ISSUE with same-cycle ready, GAP).
- Simultaneous push and pop: both take effect and the level is unchanged. A push into a full FIFO in the same cycle as a pop is accepted, with no overflow.
- Flush: clears all FIFO entries the cycle it is written.
  - A command already in ISSUE is unaffected and completes.
  - A push is impossible in the same cycle because the flush is itself the WB request.
- Overflow clear and a new overflow in the same cycle cannot happen (one WB request per cycle).
- core_ready outside ISSUE is ignored.
- Pointers wrap modulo DEPTH. Level ranges 0..DEPTH.
- Reset mid-ISSUE: core_valid drops the next cycle, and all state returns to reset values.

Decomposition:
- Package tjrpu_pkg holds:
  - register offset constants (REG_DATA=0, REG_CTRL=1, REG_READ=2)
  - status bit positions
  - control bit positions
  - FSM state enum (IDLE, ISSUE, GAP)
- Sub-module sync_fifo (WIDTH, DEPTH) provides push, pop, flush, dout, level, full and empty. It is reusable and has a registered-pointer memory.

Test Plan:
- Single command: WB write adr 0x0, sel=0011, dat=0x0000ABCD; core ready 1 cycle after valid -> ack next cycle; core_valid 2 cycles after the req with wstrb=0011, wdata=0xABCD, held until ready; status level returns to 0.
- Fill past depth: core_ready held 0; write 0x1..0x6 with DEPTH=4 -> first issued, next 4 buffered, 6th dropped; status = full=1, overflow=1, level=4; irq=1. Write ctrl 0x1 -> overflow=0, irq=0.
- Readback: core returns rdata=0x1234 on a read-only command pushed via adr 0x8 -> core_wstrb=0; reading adr 0x4 returns 0x00001234.
- GAP rule: two queued commands with core_ready asserted the same cycle as valid -> core_valid is low for at least one cycle between the two commands; each command is issued exactly once.
- Flush mid-issue: 3 commands queued, first in ISSUE; write ctrl 0x2 -> level=0 next cycle; the first command completes on ready; no further core_valid.
- Reset during ISSUE: assert reset for 1 cycle -> next cycle core_valid=0, status reads 0x100 (empty), last_rdata=0.
